// File: rtl/gpio_pkg.sv
// Shared register map and bus address layout for the Wishbone GPIO bank.
package gpio_pkg;

    localparam int ADR_W  = 5;
    localparam int LANE_W = 2;

    // Upper address bits select the register, lower bits select the byte lane.
    typedef enum logic [2:0] {
        REG_OUT     = 3'd0,
        REG_DIR     = 3'd1,
        REG_IN      = 3'd2,
        REG_SET     = 3'd3,
        REG_CLR     = 3'd4,
        REG_RISE_EN = 3'd5,
        REG_FALL_EN = 3'd6,
        REG_PEND    = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// One-pin input synchroniser with a history flop for rising/falling edge detection.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/gpio_wbn.sv
// Wishbone GPIO bank: byte-lane register decode, edge-interrupt pending logic and tri-state pins.
module gpio_wbn
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             I_wb_clk,
    input  logic             I_reset,
    input  logic [ADR_W-1:0] I_wb_adr,
    input  logic [7:0]       I_wb_dat,
    input  logic             I_wb_stb,
    input  logic             I_wb_we,
    output logic             O_wb_ack,
    output logic [7:0]       O_wb_dat,
    inout  wire  [WIDTH-1:0] GPIO_port,
    output logic             O_irq
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ack_q, ack_d;
    logic [7:0]       dat_q, dat_d;
    logic             irq_q;

    logic [WIDTH-1:0] in_sync, rise, fall;
    logic [WIDTH-1:0] lane_mask, wr_bits, w1c, rd_word;
    logic [7:0]       rd_byte;
    logic             access, wr_en, rd_en;
    reg_idx_e         reg_sel;
    logic [LANE_W-1:0] lane;

    assign reg_sel = reg_idx_e'(I_wb_adr[ADR_W-1:LANE_W]);
    assign lane    = I_wb_adr[LANE_W-1:0];
    // Ack in flight blocks a second access, so a held strobe acks every other cycle.
    assign access  = I_wb_stb & ~ack_q;
    assign wr_en   = access & I_wb_we;
    assign rd_en   = access & ~I_wb_we;
    assign wr_bits = {NB{I_wb_dat}} & lane_mask;

    for (genvar k = 0; k < WIDTH; k++) begin : g_pin
        gpio_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk_i  (I_wb_clk),
            .reset_i(I_reset),
            .pin_i  (GPIO_port[k]),
            .sync_o (in_sync[k]),
            .rise_o (rise[k]),
            .fall_o (fall[k])
        );
        assign GPIO_port[k] = dir_q[k] ? out_q[k] : 1'bz;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_OUT:     rd_word = out_q;
            REG_DIR:     rd_word = dir_q;
            REG_IN:      rd_word = in_sync;
            REG_RISE_EN: rd_word = rise_en_q;
            REG_FALL_EN: rd_word = fall_en_q;
            REG_PEND:    rd_word = pend_q;
            default:     rd_word = '0;
        endcase

        // Lanes at or above NB match nothing: mask and read byte stay zero.
        lane_mask = '0;
        rd_byte   = '0;
        for (int l = 0; l < NB; l++) begin
            if (32'(lane) == l) begin
                lane_mask[8*l +: 8] = 8'hFF;
                rd_byte             = rd_word[8*l +: 8];
            end
        end
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_OUT:     out_d     = (out_q & ~lane_mask) | wr_bits;
                REG_DIR:     dir_d     = (dir_q & ~lane_mask) | wr_bits;
                REG_SET:     out_d     = out_q | wr_bits;
                REG_CLR:     out_d     = out_q & ~wr_bits;
                REG_RISE_EN: rise_en_d = (rise_en_q & ~lane_mask) | wr_bits;
                REG_FALL_EN: fall_en_d = (fall_en_q & ~lane_mask) | wr_bits;
                REG_PEND:    w1c       = wr_bits;
                default:     w1c       = '0;
            endcase
        end
        // New edges are OR-ed in after the clear, so a same-cycle edge beats W1C.
        pend_d = (pend_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
        ack_d  = I_wb_stb & ~ack_q;
        dat_d  = rd_en ? rd_byte : dat_q;
    end

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= |pend_d;
        end
    end

    assign O_wb_ack = ack_q;
    assign O_wb_dat = dat_q;
    assign O_irq    = irq_q;

endmodule

// File: tb/tb_gpio_wbn.sv
// Directed bench for the 16-pin GPIO bank: bus access, pin drive, edge interrupts and reset.
module tb_gpio_wbn;
    import gpio_pkg::*;

    logic        clk;
    logic        I_reset;
    logic [4:0]  I_wb_adr;
    logic [7:0]  I_wb_dat;
    logic        I_wb_stb;
    logic        I_wb_we;
    logic        O_wb_ack;
    logic [7:0]  O_wb_dat;
    logic        O_irq;
    wire  [15:0] pins;
    logic [15:0] tb_oe;
    logic [15:0] tb_val;

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar k = 0; k < 16; k++) begin : g_drv
        assign pins[k] = tb_oe[k] ? tb_val[k] : 1'bz;
    end

    gpio_wbn #(
        .WIDTH(16),
        .SYNC_STAGES(2)
    ) dut (
        .I_wb_clk (clk),
        .I_reset  (I_reset),
        .I_wb_adr (I_wb_adr),
        .I_wb_dat (I_wb_dat),
        .I_wb_stb (I_wb_stb),
        .I_wb_we  (I_wb_we),
        .O_wb_ack (O_wb_ack),
        .O_wb_dat (O_wb_dat),
        .GPIO_port(pins),
        .O_irq    (O_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access from a post-edge point; returns ack and data seen just after the access edge.
    task automatic bus(input logic we, input logic [2:0] r, input logic [1:0] ln,
                       input logic [7:0] d, output logic ack_seen, output logic [7:0] rd);
        I_wb_stb = 1'b1;
        I_wb_we  = we;
        I_wb_adr = {r, ln};
        I_wb_dat = d;
        @(posedge clk);
        #1;
        ack_seen = O_wb_ack;
        rd       = O_wb_dat;
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] r, input logic [1:0] ln, input logic [7:0] d);
        logic       a;
        logic [7:0] x;
        bus(1'b1, r, ln, d, a, x);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] r, input logic [1:0] ln,
                          input logic [7:0] exp);
        logic       a;
        logic [7:0] x;
        bus(1'b0, r, ln, 8'h00, a, x);
        chk(tag, {24'h0, x}, {24'h0, exp});
    endtask

    logic       ack_s;
    logic [7:0] dat_s;
    logic [5:0] ack_hist;

    initial begin
        I_reset  = 1'b1;
        I_wb_adr = '0;
        I_wb_dat = '0;
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
        tb_oe    = '0;
        tb_val   = '0;
        idle(3);
        I_reset = 1'b0;
        chk("rst_ack", {31'h0, O_wb_ack}, 32'h0);
        chk("rst_dat", {24'h0, O_wb_dat}, 32'h0);
        chk("rst_irq", {31'h0, O_irq}, 32'h0);
        rd_chk("rst_out", REG_OUT, 2'd0, 8'h00);

        // Test 1: lane1 driven, lane0 left to the bench
        wr(REG_DIR, 2'd1, 8'hFF);
        chk("t1_ack_pre", {31'h0, O_wb_ack}, 32'h0);
        bus(1'b1, REG_OUT, 2'd1, 8'hA5, ack_s, dat_s);
        chk("t1_ack_lat", {31'h0, ack_s}, 32'h1);
        wr(REG_OUT, 2'd0, 8'h3C);
        tb_oe[7:0]  = 8'hFF;
        tb_val[7:0] = 8'hC3;
        idle(3);
        chk("t1_pins_hi", {24'h0, pins[15:8]}, 32'hA5);
        rd_chk("t1_in_lo", REG_IN, 2'd0, 8'hC3);
        rd_chk("t1_in_hi", REG_IN, 2'd1, 8'hA5);

        // Test 2: set/clear on lane0, out-of-range lane
        tb_oe[7:0] = 8'h00;
        wr(REG_OUT, 2'd0, 8'hF0);
        wr(REG_OUT, 2'd1, 8'h00);
        wr(REG_DIR, 2'd0, 8'hFF);
        wr(REG_SET, 2'd0, 8'h0F);
        wr(REG_CLR, 2'd0, 8'h30);
        rd_chk("t2_out", REG_OUT, 2'd0, 8'hCF);
        wr(REG_RISE_EN, 2'd1, 8'h00);
        chk("t2_dat_hold", {24'h0, O_wb_dat}, 32'hCF);
        idle(3);
        rd_chk("t2_in", REG_IN, 2'd0, 8'hCF);
        rd_chk("t2_set_rd0", REG_SET, 2'd0, 8'h00);
        bus(1'b1, REG_OUT, 2'd2, 8'h55, ack_s, dat_s);
        chk("t2_lane2_ack", {31'h0, ack_s}, 32'h1);
        rd_chk("t2_out_lane2", REG_OUT, 2'd2, 8'h00);
        rd_chk("t2_out_after", REG_OUT, 2'd0, 8'hCF);
        chk("t2_pins_hi", {24'h0, pins[15:8]}, 32'h00);

        // Test 3: rising edge interrupt latency and W1C
        wr(REG_DIR, 2'd0, 8'h00);
        tb_oe[7:0]  = 8'hFF;
        tb_val[7:0] = 8'h00;
        idle(4);
        wr(REG_RISE_EN, 2'd0, 8'h01);
        tb_val[0] = 1'b1;
        idle(1);
        chk("t3_irq_c1", {31'h0, O_irq}, 32'h0);
        idle(1);
        chk("t3_irq_c2", {31'h0, O_irq}, 32'h0);
        idle(1);
        chk("t3_irq_c3", {31'h0, O_irq}, 32'h1);
        rd_chk("t3_pend", REG_PEND, 2'd0, 8'h01);
        wr(REG_PEND, 2'd0, 8'h01);
        chk("t3_irq_clr", {31'h0, O_irq}, 32'h0);
        rd_chk("t3_pend_clr", REG_PEND, 2'd0, 8'h00);

        // Test 4: W1C in the same cycle as a new rising edge
        tb_val[0] = 1'b0;
        idle(4);
        tb_val[0] = 1'b1;
        idle(4);
        chk("t4_irq_set", {31'h0, O_irq}, 32'h1);
        tb_val[0] = 1'b0;
        idle(4);
        tb_val[0] = 1'b1;
        idle(2);
        wr(REG_PEND, 2'd0, 8'h01);
        chk("t4_irq_keep", {31'h0, O_irq}, 32'h1);
        rd_chk("t4_pend_keep", REG_PEND, 2'd0, 8'h01);

        // Falling edge on pin1
        wr(REG_FALL_EN, 2'd0, 8'h02);
        tb_val[1] = 1'b1;
        idle(4);
        rd_chk("t4_no_rise1", REG_PEND, 2'd0, 8'h01);
        tb_val[1] = 1'b0;
        idle(4);
        rd_chk("t4_fall1", REG_PEND, 2'd0, 8'h03);
        wr(REG_PEND, 2'd0, 8'hFF);
        rd_chk("t4_pend_all", REG_PEND, 2'd0, 8'h00);
        chk("t4_irq_low", {31'h0, O_irq}, 32'h0);

        // Test 5: strobe held for six cycles
        I_wb_stb = 1'b1;
        I_wb_we  = 1'b1;
        I_wb_adr = {REG_SET, 2'd1};
        I_wb_dat = 8'h01;
        ack_hist = '0;
        repeat (6) begin
            @(posedge clk);
            #1;
            ack_hist = {ack_hist[4:0], O_wb_ack};
        end
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
        idle(1);
        chk("t5_ack_seq", {26'h0, ack_hist}, 32'h2A);
        rd_chk("t5_out", REG_OUT, 2'd1, 8'h01);
        chk("t5_pins_hi", {24'h0, pins[15:8]}, 32'h01);

        // Test 6: reset during a read strobe
        wr(REG_OUT, 2'd1, 8'hFF);
        tb_val[0] = 1'b0;
        idle(4);
        tb_val[0] = 1'b1;
        idle(4);
        chk("t6_irq_pre", {31'h0, O_irq}, 32'h1);
        I_wb_stb = 1'b1;
        I_wb_we  = 1'b0;
        I_wb_adr = {REG_OUT, 2'd1};
        I_reset  = 1'b1;
        @(posedge clk);
        #1;
        I_reset  = 1'b0;
        I_wb_stb = 1'b0;
        chk("t6_ack", {31'h0, O_wb_ack}, 32'h0);
        chk("t6_dat", {24'h0, O_wb_dat}, 32'h00);
        chk("t6_irq", {31'h0, O_irq}, 32'h0);
        tb_oe[15:8]  = 8'hFF;
        tb_val[15:8] = 8'h5A;
        idle(3);
        rd_chk("t6_in_hi_z", REG_IN, 2'd1, 8'h5A);
        rd_chk("t6_out", REG_OUT, 2'd1, 8'h00);
        rd_chk("t6_dir", REG_DIR, 2'd1, 8'h00);
        rd_chk("t6_rise_en", REG_RISE_EN, 2'd0, 8'h00);
        rd_chk("t6_pend", REG_PEND, 2'd0, 8'h00);
        bus(1'b0, REG_OUT, 2'd3, 8'h00, ack_s, dat_s);
        chk("t6_lane3_ack", {31'h0, ack_s}, 32'h1);
        chk("t6_lane3_dat", {24'h0, dat_s}, 32'h00);
        rd_chk("t6_in_lane3", REG_IN, 2'd3, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
